// File: rtl/mc14500b_pkg.sv
// Shared types for the MC14500B ICU program sequencer: PC width, PC type and sequencer states.
package mc14500b_pkg;

    localparam int ADDR_W = 8;

    typedef logic [ADDR_W-1:0] pc_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_STEP = 2'd2,
        SEQ_HALT = 2'd3
    } seq_state_t;

    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/mc14500b_ret_stack.sv
// Return-address LIFO for JMP-as-call. Overflowing pushes and underflowing pops are dropped;
// the sequencer detects those cases from full/empty and flags them itself.
module mc14500b_ret_stack
    import mc14500b_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_clear,
    input  pc_t        i_data,
    output pc_t        o_top,
    output logic [4:0] o_count,
    output logic       o_full,
    output logic       o_empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pc_t              r_mem [DEPTH];
    logic [4:0]       r_count;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = IDX_W'(r_count);
    assign w_rd_idx = IDX_W'(r_count - 5'd1);
    assign o_full   = (r_count == 5'(DEPTH));
    assign o_empty  = (r_count == 5'd0);
    assign o_count  = r_count;
    assign o_top    = o_empty ? '0 : r_mem[w_rd_idx];

    // Entries are never read above the occupancy count, so the array needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 5'd0;
        end else if (i_clear) begin
            r_count <= 5'd0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + 5'd1;
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - 5'd1;
        end
    end

endmodule

// File: rtl/mc14500b_sequencer.sv
// Program sequencer for an MC14500B ICU: PC, run/step/halt control, call/return stack,
// FLG0 halt and FLGF loop policies.
//
// state    | meaning
// SEQ_IDLE | paused, CPU_EN=0; RUN starts free-run, STEP executes one instruction
// SEQ_RUN  | free-run, CPU_EN=1; drops to IDLE after the instruction in flight when RUN=0
// SEQ_STEP | one executed instruction, then back to IDLE
// SEQ_HALT | stopped by FLG0 or a stack fault; only RESTART or reset leave it
module mc14500b_sequencer
    import mc14500b_pkg::*;
#(
    parameter pc_t START_ADDRESS = 8'h00,
    parameter int  STACK_DEPTH   = 4,
    parameter bit  CALL_ON_JMP   = 1'b1,
    parameter bit  FLG0_HALT     = 1'b0,
    parameter bit  FLGF_LOOP     = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_step,
    input  logic       i_restart,
    input  pc_t        i_rom_data,
    input  logic       i_jmp,
    input  logic       i_rtn,
    input  logic       i_flg0,
    input  logic       i_flgf,
    output pc_t        o_addr,
    output logic       o_cpu_en,
    output logic       o_halted,
    output logic       o_stk_ovf,
    output logic       o_stk_unf,
    output logic [3:0] o_sp,
    output pc_t        o_trace
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    pc_t        r_pc;
    pc_t        w_pc_nxt;
    pc_t        r_trace;
    logic       r_ovf;
    logic       r_unf;

    logic       w_cpu_en;
    logic       w_halt_flg0;
    logic       w_push_req;
    logic       w_pop_req;
    logic       w_loop;
    logic       w_exec_fault;
    logic       w_ovf_evt;
    logic       w_unf_evt;
    logic       w_push;
    logic       w_pop;
    logic       w_clear;

    pc_t        w_stk_top;
    logic [4:0] w_stk_count;
    logic       w_stk_full;
    logic       w_stk_empty;

    mc14500b_ret_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (pc_inc(r_pc)),
        .o_top   (w_stk_top),
        .o_count (w_stk_count),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    // RESTART kills the enable in its own cycle so the ICU never sees a half-cancelled instruction.
    assign w_cpu_en = !i_restart && ((r_state == SEQ_RUN) || (r_state == SEQ_STEP));

    always_comb begin
        w_pc_nxt    = pc_inc(r_pc);
        w_halt_flg0 = 1'b0;
        w_push_req  = 1'b0;
        w_pop_req   = 1'b0;
        w_loop      = 1'b0;
        if (i_flg0 && FLG0_HALT) begin
            w_halt_flg0 = 1'b1;
            w_pc_nxt    = r_pc;
        end else if (i_jmp) begin
            w_pc_nxt   = i_rom_data;
            w_push_req = CALL_ON_JMP;
        end else if (i_rtn) begin
            w_pop_req = 1'b1;
            w_pc_nxt  = w_stk_empty ? r_pc : w_stk_top;
        end else if (i_flgf && FLGF_LOOP) begin
            w_loop   = 1'b1;
            w_pc_nxt = START_ADDRESS;
        end
    end

    assign w_exec_fault = w_halt_flg0 || (w_push_req && w_stk_full) || (w_pop_req && w_stk_empty);
    assign w_ovf_evt    = w_cpu_en && w_push_req && w_stk_full;
    assign w_unf_evt    = w_cpu_en && w_pop_req && w_stk_empty;
    assign w_push       = w_cpu_en && w_push_req && !w_stk_full;
    assign w_pop        = w_cpu_en && w_pop_req && !w_stk_empty;
    assign w_clear      = i_restart || (w_cpu_en && w_loop);

    always_comb begin
        w_state_nxt = r_state;
        if (i_restart) begin
            w_state_nxt = SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (i_run) begin
                        w_state_nxt = SEQ_RUN;
                    end else if (i_step) begin
                        w_state_nxt = SEQ_STEP;
                    end
                end
                SEQ_RUN: begin
                    if (w_exec_fault) begin
                        w_state_nxt = SEQ_HALT;
                    end else if (!i_run) begin
                        w_state_nxt = SEQ_IDLE;
                    end
                end
                // Always returning to IDLE keeps a held STEP from executing twice in a row.
                SEQ_STEP: begin
                    w_state_nxt = w_exec_fault ? SEQ_HALT : SEQ_IDLE;
                end
                SEQ_HALT: begin
                    w_state_nxt = SEQ_HALT;
                end
                default: begin
                    w_state_nxt = SEQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEQ_IDLE;
            r_pc    <= START_ADDRESS;
            r_trace <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_restart) begin
                r_pc  <= START_ADDRESS;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else if (w_cpu_en) begin
                r_pc    <= w_pc_nxt;
                r_trace <= r_pc;
                if (w_ovf_evt) begin
                    r_ovf <= 1'b1;
                end
                if (w_unf_evt) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

    assign o_addr    = r_pc;
    assign o_cpu_en  = w_cpu_en;
    assign o_halted  = (r_state == SEQ_HALT);
    assign o_stk_ovf = r_ovf;
    assign o_stk_unf = r_unf;
    // A 16-deep stack can hold 16 entries; the 4-bit port saturates at 15 for that one case.
    assign o_sp      = (w_stk_count > 5'd15) ? 4'hF : w_stk_count[3:0];
    assign o_trace   = r_trace;

endmodule
